// File: rtl/exe_muldiv_unit_if.sv
// Request/result bus of the iterative multiply/divide unit.
// The master side issues operations and consumes results; the slave side is the unit.
interface exe_muldiv_unit_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [2:0]       in_fun3;
  logic             in_word;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_fun3, in_word, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_data, out_tag, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_fun3, in_word, in_tag, flush, out_ready,
    output in_ready, out_valid, out_data, out_tag, busy
  );
endinterface

// File: rtl/exe_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the execute stage.
// One result bit per cycle: shift-add multiply on magnitudes, restoring division.
// Sign handling is done once up front (magnitudes) and once at the end (negation).
module exe_muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  exe_muldiv_unit_if.slave bus
);

  localparam int              CW    = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO  = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] X_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] W_MIN = XLEN'($signed(32'h8000_0000));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  // Extend the low word of v to XLEN, signed or unsigned.
  function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v, input logic sgn);
    logic [XLEN-1:0] r;
    if (sgn) begin
      r = XLEN'($signed(v[31:0]));
    end else begin
      r = XLEN'(v[31:0]);
    end
    return r;
  endfunction

  state_t            state_r, state_nxt_s;
  logic [XLEN-1:0]   a_r, b_r;
  logic [2:0]        fun3_r;
  logic              word_r;
  logic [TAG_W-1:0]  tag_r;
  logic [CW-1:0]     cnt_r;
  logic              neg_q_r, neg_r_r;   // negate product/quotient, negate remainder
  logic              sp_r;
  logic [XLEN-1:0]   sp_res_r;
  logic [2*XLEN-1:0] mcand_r, prod_r;
  logic [XLEN-1:0]   mplier_r;
  logic [XLEN-1:0]   quo_r, rem_r, dvsr_r;
  logic [XLEN-1:0]   out_data_r;
  logic [TAG_W-1:0]  out_tag_r;

  logic              word_in_s, accept_s;
  logic              a_sgn_s, b_sgn_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0]   a_ext_s, b_ext_s, a_mag_s, b_mag_s;
  logic              div_zero_s, ovf_s, sp_s;
  logic [XLEN-1:0]   sp_res_s;
  logic [XLEN:0]     trial_s, diff_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quo_fix_s, rem_fix_s, raw_s, res_s;

  // The W variants only exist on a 64-bit datapath.
  assign word_in_s = (XLEN == 64) ? bus.in_word : 1'b0;
  assign accept_s  = bus.in_valid && (state_r == IDLE) && !bus.flush;

  // Operand signedness, W-mode extension and magnitudes from the latched request.
  always_comb begin
    a_sgn_s = 1'b0;
    b_sgn_s = 1'b0;
    if (fun3_r[2]) begin
      a_sgn_s = ~fun3_r[0];
      b_sgn_s = ~fun3_r[0];
    end else if (!word_r) begin
      case (fun3_r[1:0])
        2'b01:   begin a_sgn_s = 1'b1; b_sgn_s = 1'b1; end
        2'b10:   begin a_sgn_s = 1'b1; b_sgn_s = 1'b0; end
        default: begin a_sgn_s = 1'b0; b_sgn_s = 1'b0; end
      endcase
    end else begin
      a_sgn_s = 1'b0;   // MULW: only the low word matters, signs are irrelevant
      b_sgn_s = 1'b0;
    end
    a_ext_s = word_r ? ext32(a_r, a_sgn_s) : a_r;
    b_ext_s = word_r ? ext32(b_r, b_sgn_s) : b_r;
    a_neg_s = a_sgn_s & a_ext_s[XLEN-1];
    b_neg_s = b_sgn_s & b_ext_s[XLEN-1];
    a_mag_s = a_neg_s ? (ZERO - a_ext_s) : a_ext_s;
    b_mag_s = b_neg_s ? (ZERO - b_ext_s) : b_ext_s;
  end

  // Division corner cases that bypass the iteration.
  always_comb begin
    div_zero_s = fun3_r[2] && (b_ext_s == ZERO);
    ovf_s      = fun3_r[2] && !fun3_r[0] && (b_ext_s == ONES) &&
                 (a_ext_s == (word_r ? W_MIN : X_MIN));
    sp_s       = div_zero_s || ovf_s;
    sp_res_s   = ZERO;
    if (div_zero_s) begin
      sp_res_s = fun3_r[1] ? a_ext_s : ONES;
    end else if (ovf_s) begin
      sp_res_s = fun3_r[1] ? ZERO : a_ext_s;
    end else begin
      sp_res_s = ZERO;
    end
  end

  // Restoring-division trial subtraction for the current step.
  always_comb begin
    trial_s = {rem_r, quo_r[XLEN-1]};
    diff_s  = trial_s - {1'b0, dvsr_r};
  end

  // Sign correction and half/quotient/remainder selection for the final cycle.
  always_comb begin
    prod_fix_s = neg_q_r ? ({(2*XLEN){1'b0}} - prod_r) : prod_r;
    quo_fix_s  = neg_q_r ? (ZERO - quo_r) : quo_r;
    rem_fix_s  = neg_r_r ? (ZERO - rem_r) : rem_r;
    raw_s      = ZERO;
    if (sp_r) begin
      raw_s = sp_res_r;
    end else if (fun3_r[2]) begin
      raw_s = fun3_r[1] ? rem_fix_s : quo_fix_s;
    end else if (!word_r && (fun3_r[1:0] != 2'b00)) begin
      raw_s = prod_fix_s[2*XLEN-1:XLEN];
    end else begin
      raw_s = prod_fix_s[XLEN-1:0];
    end
    res_s = word_r ? ext32(raw_s, 1'b1) : raw_s;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; flush wins over everything, including accept and out_ready.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = bus.in_valid ? PREP : IDLE;
        PREP:    state_nxt_s = CALC;
        CALC:    state_nxt_s = (cnt_r == {CW{1'b0}}) ? DONE : CALC;
        DONE:    state_nxt_s = bus.out_ready ? IDLE : DONE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Datapath: latch, prepare, iterate, then publish the result on entry to DONE.
  // Special cases load a zero count so they take only the result cycle in CALC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r        <= ZERO;
      b_r        <= ZERO;
      fun3_r     <= 3'd0;
      word_r     <= 1'b0;
      tag_r      <= {TAG_W{1'b0}};
      cnt_r      <= {CW{1'b0}};
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      sp_r       <= 1'b0;
      sp_res_r   <= ZERO;
      mcand_r    <= {(2*XLEN){1'b0}};
      prod_r     <= {(2*XLEN){1'b0}};
      mplier_r   <= ZERO;
      quo_r      <= ZERO;
      rem_r      <= ZERO;
      dvsr_r     <= ZERO;
      out_data_r <= ZERO;
      out_tag_r  <= {TAG_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r    <= bus.in_a;
            b_r    <= bus.in_b;
            fun3_r <= bus.in_fun3;
            word_r <= word_in_s;
            tag_r  <= bus.in_tag;
          end
        end
        PREP: begin
          neg_q_r  <= a_neg_s ^ b_neg_s;
          neg_r_r  <= a_neg_s;
          sp_r     <= sp_s;
          sp_res_r <= sp_res_s;
          mcand_r  <= {ZERO, a_mag_s};
          mplier_r <= b_mag_s;
          prod_r   <= {(2*XLEN){1'b0}};
          rem_r    <= ZERO;
          // A 32-step divide must see the dividend in the top word.
          quo_r    <= word_r ? (a_mag_s << (XLEN - 32)) : a_mag_s;
          dvsr_r   <= b_mag_s;
          if (sp_s) begin
            cnt_r <= {CW{1'b0}};
          end else begin
            cnt_r <= word_r ? CW'(32) : CW'(XLEN);
          end
        end
        CALC: begin
          if (cnt_r != {CW{1'b0}}) begin
            cnt_r <= cnt_r - CW'(1);
            if (fun3_r[2]) begin
              if (!diff_s[XLEN]) begin
                rem_r <= diff_s[XLEN-1:0];
                quo_r <= {quo_r[XLEN-2:0], 1'b1};
              end else begin
                rem_r <= trial_s[XLEN-1:0];
                quo_r <= {quo_r[XLEN-2:0], 1'b0};
              end
            end else begin
              if (mplier_r[0]) begin
                prod_r <= prod_r + mcand_r;
              end
              mcand_r  <= mcand_r << 1;
              mplier_r <= mplier_r >> 1;
            end
          end else if (!bus.flush) begin
            out_data_r <= res_s;
            out_tag_r  <= tag_r;
          end
        end
        DONE: begin
          out_data_r <= out_data_r;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.busy      = (state_r != IDLE);
  assign bus.out_valid = (state_r == DONE);
  assign bus.out_data  = out_data_r;
  assign bus.out_tag   = out_tag_r;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Self-checking bench for exe_muldiv_unit (XLEN=64): directed vector table,
// multi-cycle corner sequences, and random ops against an arithmetic reference.
module tb_exe_muldiv_unit;
  localparam int XLEN  = 64;
  localparam int TAG_W = 64;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  exe_muldiv_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus_if ();

  exe_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  f;
    logic        w;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input string n, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] f, input logic w, input logic [63:0] e, input int l);
    vec_t v;
    v.name = n; v.a = a; v.b = b; v.f = f; v.w = w; v.exp = e; v.lat = l;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result computed straight from the M-extension definitions.
  function automatic logic [63:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic [2:0] f, input logic w);
    logic signed [127:0] pa, pb, pp;
    logic signed [63:0]  sa, sb;
    logic signed [31:0]  wa, wb;
    logic [31:0]         r32;
    logic [63:0]         r;
    logic                ovf64, ovf32;
    sa = a; sb = b; wa = a[31:0]; wb = b[31:0];
    r = 64'd0; r32 = 32'd0;
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    pa = {{64{a[63]}}, a};
    pb = {{64{b[63]}}, b};
    if (f == 3'd3) pa = {64'd0, a};
    if (f == 3'd2 || f == 3'd3) pb = {64'd0, b};
    pp = pa * pb;
    if (w) begin
      case (f)
        3'd4: if (b[31:0] == 32'd0) r32 = 32'hFFFF_FFFF; else if (ovf32) r32 = a[31:0]; else r32 = wa / wb;
        3'd5: if (b[31:0] == 32'd0) r32 = 32'hFFFF_FFFF; else r32 = a[31:0] / b[31:0];
        3'd6: if (b[31:0] == 32'd0) r32 = a[31:0]; else if (ovf32) r32 = 32'd0; else r32 = wa % wb;
        3'd7: if (b[31:0] == 32'd0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
        default: r32 = a[31:0] * b[31:0];
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (f)
        3'd0: r = a * b;
        3'd4: if (b == 64'd0) r = 64'hFFFF_FFFF_FFFF_FFFF; else if (ovf64) r = a; else r = sa / sb;
        3'd5: if (b == 64'd0) r = 64'hFFFF_FFFF_FFFF_FFFF; else r = a / b;
        3'd6: if (b == 64'd0) r = a; else if (ovf64) r = 64'd0; else r = sa % sb;
        3'd7: if (b == 64'd0) r = a; else r = a % b;
        default: r = pp[127:64];
      endcase
    end
    return r;
  endfunction

  // Expected accept-to-valid cycles: short path for divide-by-zero and overflow.
  function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b,
                                 input logic [2:0] f, input logic w);
    logic zero, ovf;
    if (w) begin
      zero = (b[31:0] == 32'd0);
      ovf  = !f[0] && (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    end else begin
      zero = (b == 64'd0);
      ovf  = !f[0] && (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    end
    if (f[2] && (zero || ovf)) return 2;
    return w ? 34 : 66;
  endfunction

  function automatic logic [63:0] rand_operand();
    logic [63:0] v;
    int sel;
    sel = int'($urandom_range(0, 7));
    case (sel)
      0: v = 64'd0;
      1: v = 64'hFFFF_FFFF_FFFF_FFFF;
      2: v = 64'h8000_0000_0000_0000;
      3: v = 64'hFFFF_FFFF_8000_0000;
      4: v = 64'($urandom_range(0, 20));
      5: v = {32'd0, $urandom};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Issue one request and wait (bounded) for out_valid; latency counted in edges after accept.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f,
                        input logic w, input logic [63:0] tag,
                        output logic [63:0] res, output logic [63:0] tg, output int lat);
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.in_a     = a;
    bus_if.in_b     = b;
    bus_if.in_fun3  = f;
    bus_if.in_word  = w;
    bus_if.in_tag   = tag;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    bus_if.in_a     = {$urandom, $urandom};
    bus_if.in_b     = {$urandom, $urandom};
    bus_if.in_tag   = ~tag;
    lat = 0;
    while (bus_if.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus_if.out_data;
    tg  = bus_if.out_tag;
  endtask

  // Hand the result back, or abort with a flush if it never came.
  task automatic finish_op(input int lat);
    if (lat >= 200) begin
      @(negedge clk);
      bus_if.flush = 1'b1;
      @(negedge clk);
      bus_if.flush = 1'b0;
    end else begin
      bus_if.out_ready = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] res, tg, tag, a, b, exp;
    logic [2:0]  f;
    logic        w;
    int          lat, pulses;

    reset_n          = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_a      = 64'd0;
    bus_if.in_b      = 64'd0;
    bus_if.in_fun3   = 3'd0;
    bus_if.in_word   = 1'b0;
    bus_if.in_tag    = 64'd0;
    bus_if.flush     = 1'b0;
    bus_if.out_ready = 1'b1;

    add_vec("mul_7_m3",     64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB, 66);
    add_vec("mulhu_ones",   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 66);
    add_vec("mulhsu_m1_2",  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    add_vec("mulh_m1_m1",   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0, 64'd0, 66);
    add_vec("divw_by0",     64'h1_0000_0005, 64'd0, 3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    add_vec("remw_by0",     64'h1_0000_0005, 64'd0, 3'd6, 1'b1, 64'd5, 2);
    add_vec("div_ovf",      64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'd4, 1'b0, 64'h8000_0000_0000_0000, 2);
    add_vec("rem_ovf",      64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'd6, 1'b0, 64'd0, 2);
    add_vec("divu_100_7",   64'd100, 64'd7, 3'd5, 1'b0, 64'd14, 66);
    add_vec("remu_100_7",   64'd100, 64'd7, 3'd7, 1'b0, 64'd2, 66);
    add_vec("div_m7_2",     64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 66);
    add_vec("rem_m7_2",     64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 66);
    add_vec("remw_m7_2",    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 34);
    add_vec("mulw_sext",    64'h7FFF_FFFF, 64'd2, 3'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 34);
    add_vec("divu_by0",     64'd5, 64'd0, 3'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    add_vec("remu_by0",     64'd5, 64'd0, 3'd7, 1'b0, 64'd5, 2);
    add_vec("divw_ovf",     64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 3'd4, 1'b1, 64'hFFFF_FFFF_8000_0000, 2);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
    check("rst_out_data",  bus_if.out_data, 64'd0);
    check("rst_out_tag",   bus_if.out_tag, 64'd0);
    check("rst_busy",      64'(bus_if.busy), 64'd0);
    check("rst_in_ready",  64'(bus_if.in_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < vq.size(); i++) begin
      tag = 64'hA000_0000_0000_0000 + 64'(i);
      run_op(vq[i].a, vq[i].b, vq[i].f, vq[i].w, tag, res, tg, lat);
      check({vq[i].name, "_data"}, res, vq[i].exp);
      check({vq[i].name, "_lat"},  64'(lat), 64'(vq[i].lat));
      check({vq[i].name, "_tag"},  tg, tag);
      finish_op(lat);
    end

    // Backpressure: result and tag stay put while out_ready is low.
    bus_if.out_ready = 1'b0;
    tag = 64'h0000_0000_0000_BEEF;
    run_op(64'd1000, 64'd3, 3'd5, 1'b0, tag, res, tg, lat);
    check("bp_data", res, 64'd333);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 64'(bus_if.out_valid), 64'd1);
      check("bp_hold_data",  bus_if.out_data, 64'd333);
      check("bp_hold_tag",   bus_if.out_tag, tag);
      check("bp_hold_ready", 64'(bus_if.in_ready), 64'd0);
    end
    @(negedge clk);
    bus_if.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 64'(bus_if.out_valid), 64'd0);
    check("bp_release_ready", 64'(bus_if.in_ready), 64'd1);

    // Flush mid-CALC, with a competing request and out_ready high.
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.in_a     = 64'd1234567;
    bus_if.in_b     = 64'd89;
    bus_if.in_fun3  = 3'd5;
    bus_if.in_word  = 1'b0;
    bus_if.in_tag   = 64'h55;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus_if.flush    = 1'b1;
    bus_if.in_valid = 1'b1;
    @(posedge clk); #1;
    check("flush_out_valid", 64'(bus_if.out_valid), 64'd0);
    check("flush_in_ready",  64'(bus_if.in_ready), 64'd1);
    check("flush_busy",      64'(bus_if.busy), 64'd0);
    bus_if.flush    = 1'b0;
    bus_if.in_valid = 1'b0;
    pulses = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (bus_if.out_valid === 1'b1) pulses++;
    end
    check("flush_no_pulse", 64'(pulses), 64'd0);
    check("flush_data_kept", bus_if.out_data, 64'd333);
    tag = 64'h0000_0000_0000_0042;
    run_op(64'd9, 64'd2, 3'd5, 1'b1, tag, res, tg, lat);
    check("divuw_9_2_data", res, 64'd4);
    check("divuw_9_2_lat",  64'(lat), 64'd34);
    check("divuw_9_2_tag",  tg, tag);
    finish_op(lat);

    // Random ops against the reference model.
    for (int n = 0; n < 40; n++) begin
      a = rand_operand();
      b = rand_operand();
      f = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      tag = {$urandom, $urandom};
      exp = ref_model(a, b, f, w);
      run_op(a, b, f, w, tag, res, tg, lat);
      check("rand_data", res, exp);
      check("rand_lat",  64'(lat), 64'(ref_lat(a, b, f, w)));
      check("rand_tag",  tg, tag);
      if (res !== exp) $display("  op f=%0d w=%0d a=%h b=%h", f, w, a, b);
      finish_op(lat);
    end

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.in_a     = 64'd12345;
    bus_if.in_b     = 64'd678;
    bus_if.in_fun3  = 3'd0;
    bus_if.in_word  = 1'b0;
    bus_if.in_tag   = 64'h77;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus_if.out_valid), 64'd0);
    check("arst_out_data",  bus_if.out_data, 64'd0);
    check("arst_out_tag",   bus_if.out_tag, 64'd0);
    check("arst_busy",      64'(bus_if.busy), 64'd0);
    check("arst_in_ready",  64'(bus_if.in_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    tag = 64'h0000_0000_0000_0099;
    run_op(64'd12345, 64'd678, 3'd0, 1'b0, tag, res, tg, lat);
    check("post_rst_data", res, 64'd8369910);
    check("post_rst_lat",  64'(lat), 64'd66);
    finish_op(lat);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
